// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the byte-serial memory port arbiter:
// default widths, FSM state encoding and grant encoding.
package mem_port_arbiter_pkg;

  localparam int WORD_LEN = 16;
  localparam int ADDR_LEN = 16;
  localparam int CELL_LEN = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two word requesters, the arbiter and the byte memory.
// slave: the arbiter's view. master: the environment (requesters + memory).
interface mem_port_arbiter_if #(
  parameter int WORD_LEN = mem_port_arbiter_pkg::WORD_LEN,
  parameter int ADDR_LEN = mem_port_arbiter_pkg::ADDR_LEN,
  parameter int CELL_LEN = mem_port_arbiter_pkg::CELL_LEN
);
  import mem_port_arbiter_pkg::*;

  logic                f_req;
  logic [ADDR_LEN-1:0] f_addr;
  logic                f_ack;
  logic [WORD_LEN-1:0] f_rdata;

  logic                d_req;
  logic                d_we;
  logic [ADDR_LEN-1:0] d_addr;
  logic [WORD_LEN-1:0] d_wdata;
  logic                d_ack;
  logic [WORD_LEN-1:0] d_rdata;

  logic                busy;

  logic [ADDR_LEN-1:0] mem_addr;
  logic                mem_we;
  logic [CELL_LEN-1:0] mem_wdata;
  logic [CELL_LEN-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_ack, f_rdata, d_ack, d_rdata, busy, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_ack, f_rdata, d_ack, d_rdata, busy, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select between fetch and data requests.
// With MEM_ARB_RR_EN defined a tie goes to the side not granted last;
// otherwise data always beats fetch.
module arb_pick (
  input  logic                         f_req,
  input  logic                         d_req,
  input  mem_port_arbiter_pkg::grant_t last_grant,
  output mem_port_arbiter_pkg::grant_t gnt
);
  import mem_port_arbiter_pkg::*;

`ifdef MEM_ARB_RR_EN
  // Alternate on a tie; a lone requester wins regardless of the pointer
  always_comb begin
    if (f_req && d_req) begin
      gnt = (last_grant == GNT_DATA) ? GNT_FETCH : GNT_DATA;
    end else if (d_req) begin
      gnt = GNT_DATA;
    end else begin
      gnt = GNT_FETCH;
    end
  end
`else
  logic unused_pick;
  assign unused_pick = ^{f_req, last_grant};

  // Fixed priority: data over fetch
  always_comb begin
    gnt = d_req ? GNT_DATA : GNT_FETCH;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide synchronous memory between fetch and load/store.
// Each 16-bit word is two byte cycles, big-endian: high byte at a, low at a+1.
// IDLE -> HI -> LO -> DONE -> IDLE; ack pulses in DONE, 3 cycles after accept.
// Optional macro MEM_ARB_RR_EN: round-robin on ties (default: data wins).
module mem_port_arbiter #(
  parameter int WORD_LEN = mem_port_arbiter_pkg::WORD_LEN,
  parameter int ADDR_LEN = mem_port_arbiter_pkg::ADDR_LEN,
  parameter int CELL_LEN = mem_port_arbiter_pkg::CELL_LEN
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  import mem_port_arbiter_pkg::*;

  state_t              state_q;
  state_t              state_d;
  grant_t              gnt_q;
  grant_t              pick;
  grant_t              last_grant;
  logic [ADDR_LEN-1:0] addr_q;
  logic                we_q;
  logic [WORD_LEN-1:0] wdata_q;
  logic [CELL_LEN-1:0] hi_q;
  logic [WORD_LEN-1:0] f_rdata_q;
  logic [WORD_LEN-1:0] d_rdata_q;
  logic                any_req;
  logic                accept;
  logic [WORD_LEN-1:0] word_done;

  assign any_req   = bus.f_req | bus.d_req;
  assign accept    = (state_q == IDLE) && any_req;
  // Low byte arrives on mem_rdata during DONE, one cycle after LO's address
  assign word_done = {hi_q, bus.mem_rdata};

`ifdef MEM_ARB_RR_EN
  grant_t last_q;

  // Last-grant pointer, updated on every accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_DATA;
    end else if (accept) begin
      last_q <= pick;
    end
  end

  assign last_grant = last_q;
`else
  assign last_grant = GNT_DATA;
`endif

  arb_pick u_pick (
    .f_req      (bus.f_req),
    .d_req      (bus.d_req),
    .last_grant (last_grant),
    .gnt        (pick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: fixed four-cycle walk once a request is taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = HI;
      HI:      state_d = LO;
      LO:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's request; only a store carries meaningful write data
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q   <= GNT_FETCH;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      gnt_q <= pick;
      if (pick == GNT_DATA) begin
        addr_q  <= bus.d_addr;
        we_q    <= bus.d_we;
        wdata_q <= bus.d_we ? bus.d_wdata : '0;
      end else begin
        addr_q  <= bus.f_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
      end
    end
  end

  // Capture returned bytes; per-port read words hold between accesses
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q      <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (state_q == LO) begin
        hi_q <= bus.mem_rdata;
      end
      if (state_q == DONE) begin
        if (gnt_q == GNT_FETCH) begin
          f_rdata_q <= word_done;
        end else begin
          d_rdata_q <= word_done;
        end
      end
    end
  end

  // Outputs from state; rst masks writes and acks so an abort takes effect at once
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.f_ack     = 1'b0;
    bus.d_ack     = 1'b0;
    bus.f_rdata   = f_rdata_q;
    bus.d_rdata   = d_rdata_q;
    bus.busy      = (state_q != IDLE);
    case (state_q)
      HI: begin
        bus.mem_addr  = addr_q;
        bus.mem_we    = we_q & ~rst;
        bus.mem_wdata = wdata_q[WORD_LEN-1:CELL_LEN];
      end
      LO: begin
        bus.mem_addr  = addr_q + 1'b1;
        bus.mem_we    = we_q & ~rst;
        bus.mem_wdata = wdata_q[CELL_LEN-1:0];
      end
      DONE: begin
        if (gnt_q == GNT_FETCH) begin
          bus.f_ack   = ~rst;
          bus.f_rdata = word_done;
        end else begin
          bus.d_ack   = ~rst;
          bus.d_rdata = word_done;
        end
      end
      default: ;
    endcase
  end

endmodule
